// File: rtl/dm_store_queue.sv
// Store queue: forms SB/SH/SW byte enables and lane data, buffers stores in a FIFO
// and drains them over a req/ack port. Optional misaligned-store exception: DM_STORE_ALIGN_EXC_EN.

`ifndef mips_SB
`define mips_SB 6'b101000
`endif
`ifndef mips_SH
`define mips_SH 6'b101001
`endif
`ifndef mips_SW
`define mips_SW 6'b101011
`endif

module dm_store_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [5:0]    st_op,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    output logic          empty,
    output logic          exc_ades,
    output logic [AW-1:0] exc_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          is_store;
    logic          misaligned;
    logic [3:0]    be_in;
    logic [31:0]   data_in;
    logic          push, pop;

    always_comb begin
        be_in    = 4'b0000;
        data_in  = 32'h0;
        is_store = 1'b0;
        case (st_op)
            `mips_SB: begin
                is_store = 1'b1;
                be_in    = 4'b0001 << st_addr[1:0];
                data_in  = {4{st_data[7:0]}};
            end
            `mips_SH: begin
                is_store = 1'b1;
                be_in    = st_addr[1] ? 4'b1100 : 4'b0011;
                data_in  = {2{st_data[15:0]}};
            end
            `mips_SW: begin
                is_store = 1'b1;
                be_in    = 4'b1111;
                data_in  = st_data;
            end
            default: ;
        endcase
    end

`ifdef DM_STORE_ALIGN_EXC_EN
    assign misaligned = ((st_op == `mips_SH) && st_addr[0]) ||
                        ((st_op == `mips_SW) && (st_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Status is derived only from the registered count, never from st_* inputs.
    assign st_ready = (count != CW'(DEPTH));
    assign empty    = (count == '0);
    assign mem_req  = !empty;

    assign push = st_valid && st_ready && is_store && !misaligned;
    assign pop  = mem_req && mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= {st_addr[AW-1:2], 2'b00};
            be_mem[wr_ptr]   <= be_in;
            data_mem[wr_ptr] <= data_in;
        end
    end

    // Gate the head fields so an empty queue presents all-zero outputs.
    assign mem_addr  = mem_req ? addr_mem[rd_ptr] : '0;
    assign mem_be    = mem_req ? be_mem[rd_ptr]   : 4'b0000;
    assign mem_wdata = mem_req ? data_mem[rd_ptr] : 32'h0;

`ifdef DM_STORE_ALIGN_EXC_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_ades <= 1'b0;
            exc_addr <= '0;
        end else begin
            exc_ades <= st_valid && st_ready && misaligned;
            if (st_valid && st_ready && misaligned)
                exc_addr <= st_addr;
        end
    end
`else
    assign exc_ades = 1'b0;
    assign exc_addr = '0;
`endif

endmodule

// File: tb/tb_dm_store_queue.sv
// Directed self-checking bench for dm_store_queue (DEPTH=2, AW=32).
// Expectations follow DM_STORE_ALIGN_EXC_EN when it is defined.

`ifndef mips_SB
`define mips_SB 6'b101000
`endif
`ifndef mips_SH
`define mips_SH 6'b101001
`endif
`ifndef mips_SW
`define mips_SW 6'b101011
`endif

module tb_dm_store_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [5:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        empty;
    logic        exc_ades;
    logic [31:0] exc_addr;

    int checks   = 0;
    int failures = 0;

    dm_store_queue #(.DEPTH(2), .AW(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .empty     (empty),
        .exc_ades  (exc_ades),
        .exc_addr  (exc_addr)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        st_valid = 1'b0;
        st_op    = 6'h0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        mem_ack  = 1'b0;
        #12;
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++;
        if (empty !== 1'b1 || st_ready !== 1'b1) begin
            failures++; $display("FAIL reset_status empty=%b st_ready=%b exp=1/1", empty, st_ready);
        end
        checks++;
        if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_fields be=%h addr=%h wdata=%h exp=0", mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if (exc_ades !== 1'b0 || exc_addr !== 32'h0) begin
            failures++; $display("FAIL reset_exc ades=%b addr=%h exp=0", exc_ades, exc_addr);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_sb_sweep();
        logic [3:0] exp_be;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_op    = `mips_SB;
            st_addr  = 32'h1000 + i;
            st_data  = 32'h000000A5;
            tick();
            exp_be = 4'b0001 << i;
            checks++;
            if (mem_req !== 1'b1 || mem_be !== exp_be || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h1000) begin
                failures++;
                $display("FAIL sb_lane%0d req=%b be=%b wdata=%h addr=%h exp=1 %b a5a5a5a5 00001000",
                         i, mem_req, mem_be, mem_wdata, mem_addr, exp_be);
            end
        end
        st_valid = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("FAIL sb_drain req=%b empty=%b exp=0/1", mem_req, empty);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_sh_sw();
        mem_ack = 1'b0;
        push_one(`mips_SH, 32'h2002, 32'h1234BEEF);
        checks++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF || mem_addr !== 32'h2000) begin
            failures++;
            $display("FAIL sh_upper req=%b be=%b wdata=%h addr=%h exp=1 1100 beefbeef 00002000",
                     mem_req, mem_be, mem_wdata, mem_addr);
        end
        push_one(`mips_SH, 32'h2010, 32'h00005678);
        mem_ack = 1'b1;
        tick();
        checks++;
        if (mem_be !== 4'b0011 || mem_wdata !== 32'h56785678 || mem_addr !== 32'h2010) begin
            failures++;
            $display("FAIL sh_lower be=%b wdata=%h addr=%h exp=0011 56785678 00002010", mem_be, mem_wdata, mem_addr);
        end
        tick();
        mem_ack = 1'b0;
        push_one(`mips_SW, 32'h2004, 32'hCAFEF00D);
        checks++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h2004) begin
            failures++;
            $display("FAIL sw_word req=%b be=%b wdata=%h addr=%h exp=1 1111 cafef00d 00002004",
                     mem_req, mem_be, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL sw_drain empty=%b exp=1", empty); end
    endtask

    task automatic test_backpressure();
        mem_ack  = 1'b0;
        st_valid = 1'b1;
        st_op    = `mips_SW;
        st_addr  = 32'h4000; st_data = 32'h11111111;
        tick();
        st_addr  = 32'h4004; st_data = 32'h22222222;
        tick();
        st_addr  = 32'h4008; st_data = 32'h33333333;
        checks++;
        if (st_ready !== 1'b0 || empty !== 1'b0) begin
            failures++; $display("FAIL bp_full st_ready=%b empty=%b exp=0/0", st_ready, empty);
        end
        tick();
        tick();
        checks++;
        if (mem_addr !== 32'h4000 || mem_wdata !== 32'h11111111 || mem_be !== 4'hF || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable addr=%h wdata=%h be=%b req=%b exp=00004000 11111111 1111 1",
                     mem_addr, mem_wdata, mem_be, mem_req);
        end
        mem_ack = 1'b1;
        tick();
        checks++;
        if (st_ready !== 1'b1 || mem_addr !== 32'h4004 || mem_wdata !== 32'h22222222) begin
            failures++;
            $display("FAIL bp_pop1 st_ready=%b addr=%h wdata=%h exp=1 00004004 22222222", st_ready, mem_addr, mem_wdata);
        end
        tick();
        st_valid = 1'b0;
        checks++;
        if (mem_addr !== 32'h4008 || mem_wdata !== 32'h33333333 || st_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_third addr=%h wdata=%h st_ready=%b exp=00004008 33333333 1", mem_addr, mem_wdata, st_ready);
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (empty !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL bp_drain empty=%b req=%b exp=1/0", empty, mem_req);
        end
    endtask

    task automatic test_push_pop();
        mem_ack = 1'b0;
        push_one(`mips_SW, 32'h5000, 32'hAAAA0000);
        st_valid = 1'b1;
        st_op    = `mips_SW;
        st_addr  = 32'h5004;
        st_data  = 32'hBBBB0000;
        mem_ack  = 1'b1;
        checks++;
        if (mem_addr !== 32'h5000) begin failures++; $display("FAIL pp_older addr=%h exp=00005000", mem_addr); end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_addr !== 32'h5004 || mem_req !== 1'b1 || st_ready !== 1'b1) begin
            failures++;
            $display("FAIL pp_count1 addr=%h req=%b st_ready=%b exp=00005004 1 1", mem_addr, mem_req, st_ready);
        end
        st_addr = 32'h5008;
        st_data = 32'hCCCC0000;
        tick();
        st_valid = 1'b0;
        checks++;
        if (st_ready !== 1'b0 || mem_addr !== 32'h5004) begin
            failures++; $display("FAIL pp_fill st_ready=%b addr=%h exp=0 00005004", st_ready, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        checks++;
        if (mem_addr !== 32'h5008 || mem_wdata !== 32'hCCCC0000) begin
            failures++; $display("FAIL pp_order addr=%h wdata=%h exp=00005008 cccc0000", mem_addr, mem_wdata);
        end
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_non_store();
        push_one(6'h23, 32'h6000, 32'h12345678);
        checks++;
        if (mem_req !== 1'b0 || empty !== 1'b1 || exc_ades !== 1'b0) begin
            failures++; $display("FAIL non_store req=%b empty=%b ades=%b exp=0 1 0", mem_req, empty, exc_ades);
        end
    endtask

    task automatic test_misaligned();
        mem_ack = 1'b0;
        push_one(`mips_SW, 32'h3001, 32'hDEADBEEF);
`ifdef DM_STORE_ALIGN_EXC_EN
        checks++;
        if (exc_ades !== 1'b1 || exc_addr !== 32'h3001 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mis_sw_exc ades=%b exc_addr=%h req=%b exp=1 00003001 0", exc_ades, exc_addr, mem_req);
        end
        tick();
        checks++;
        if (exc_ades !== 1'b0 || exc_addr !== 32'h3001 || empty !== 1'b1) begin
            failures++;
            $display("FAIL mis_sw_pulse ades=%b exc_addr=%h empty=%b exp=0 00003001 1", exc_ades, exc_addr, empty);
        end
        push_one(`mips_SH, 32'h3003, 32'h0000ABCD);
        checks++;
        if (exc_ades !== 1'b1 || exc_addr !== 32'h3003 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mis_sh_exc ades=%b exc_addr=%h req=%b exp=1 00003003 0", exc_ades, exc_addr, mem_req);
        end
        tick();
`else
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL mis_sw_enq req=%b addr=%h be=%b wdata=%h exp=1 00003000 1111 deadbeef",
                     mem_req, mem_addr, mem_be, mem_wdata);
        end
        checks++;
        if (exc_ades !== 1'b0 || exc_addr !== 32'h0) begin
            failures++; $display("FAIL mis_no_exc ades=%b exc_addr=%h exp=0 0", exc_ades, exc_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        push_one(`mips_SH, 32'h3003, 32'h0000ABCD);
        checks++;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h3000) begin
            failures++;
            $display("FAIL mis_sh_enq be=%b wdata=%h addr=%h exp=1100 abcdabcd 00003000", mem_be, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_drain();
        mem_ack = 1'b0;
        push_one(`mips_SW, 32'h7000, 32'h01010101);
        push_one(`mips_SW, 32'h7004, 32'h02020202);
        checks++;
        if (mem_req !== 1'b1 || st_ready !== 1'b0) begin
            failures++; $display("FAIL rst_pre req=%b st_ready=%b exp=1 0", mem_req, st_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1 || mem_be !== 4'h0) begin
            failures++;
            $display("FAIL rst_async req=%b empty=%b st_ready=%b be=%b exp=0 1 1 0000", mem_req, empty, st_ready, mem_be);
        end
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b0 || empty !== 1'b1) begin
            failures++; $display("FAIL rst_stale req=%b empty=%b exp=0 1", mem_req, empty);
        end
    endtask

    initial begin
        test_reset();
        test_sb_sweep();
        test_sh_sw();
        test_backpressure();
        test_push_pop();
        test_non_store();
        test_misaligned();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_store_queue.md
Name: dm_store_queue

Overview:
- Store-side counterpart of the load extender. Accepts SB/SH/SW requests from the MEM stage and builds the per-lane byte enables and lane-shifted write data.
- Buffers stores in a small FIFO and drains them to the data-memory/bridge port over a req/ack handshake.
- Sits between the MEM pipeline register and the DM/bridge. Detects misaligned stores for the CP0 AdES path.

Parameters:
- DEPTH, 2, number of store-queue entries (power of two, ≥2).
- AW, 32, address width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  queue can accept (not full).
- st_op  in  6  instruction code; `mips_SB / `mips_SH / `mips_SW from macrodefine.v.
- st_addr  in  AW  byte address.
- st_data  in  32  rt value, right-justified.
- mem_req  out  1  head entry valid toward memory.
- mem_ack  in  1  memory accepted head this cycle.
- mem_addr  out  AW  word-aligned address ({st_addr[AW-1:2],2'b00}).
- mem_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i]).
- mem_wdata  out  32  lane-positioned write data.
- empty  out  1  queue empty (used for sync/eret drain).
- exc_ades  out  1  one-cycle misaligned-store pulse.
- exc_addr  out  AW  faulting byte address (BadVAddr).

Behaviour:
- Reset (async, reset_n=0): queue pointers and count cleared; mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, exc_ades=0, exc_addr=0, empty=1, st_ready=1. A reset mid-drain discards all entries; mem_req falls with reset, not at the next edge.
- Handshake in: a transfer occurs when st_valid && st_ready at a rising edge. st_ready = (count != DEPTH), combinational from registered count only.
- Lane formation at enqueue:
  - SB: be = 1<<addr[1:0]; data = {4{st_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; data = {2{st_data[15:0]}}.
  - SW: be = 4'b1111; data = st_data.
  - Stored entry = {word addr, be, data}.
- Non-store op with st_valid: accepted (consumes handshake), not enqueued, no exception.
- Latency: store accepted at edge T into an empty queue → mem_req=1 with its fields from T+1. Outputs are driven from the registered head entry, with no combinational path from st_*.
- Handshake out:
  - Pop when mem_req && mem_ack at an edge.
  - mem_addr/mem_be/mem_wdata are stable while mem_req=1 and not yet acked.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop: allowed whenever st_ready=1; count unchanged; FIFO order preserved. When full, no push that cycle even if a pop occurs; st_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. count width = clog2(DEPTH)+1.
- empty = (count==0), registered-equivalent.
- Order: strict FIFO. Stores to the same word are never merged or reordered.

Optional Feature:
- Macro: DM_STORE_ALIGN_EXC_EN.
- Defined:
  - SH with addr[0]=1, or SW with addr[1:0]!=0, is accepted but not enqueued.
  - exc_ades=1 for exactly the cycle after acceptance; exc_addr = the original byte address, held until the next exception.
  - A misaligned store and a pop in the same cycle: pop proceeds normally.
- Undefined:
  - No exception; exc_ades and exc_addr are tied to 0.
  - Misaligned SH/SW enqueue with the low address bits ignored: SH uses addr[1], SW forces aligned be=4'b1111.

Test Plan:
- SB sweep, mem_ack=1: addr 0x1000–0x1003, data 0x000000A5 → be 0001/0010/0100/1000, wdata 0xA5A5A5A5, mem_addr 0x1000, each mem_req one cycle after acceptance.
- SH/SW: SH addr 0x2002 data 0x1234BEEF → be 1100, wdata 0xBEEFBEEF; SW addr 0x2004 data 0xCAFEF00D → be 1111, wdata 0xCAFEF00D.
- Backpressure: mem_ack=0, three SW back-to-back → first two accepted, st_ready=0 on the third, empty=0. Release mem_ack → pops in order; third accepted the cycle after st_ready rises; mem fields stable while stalled.
- Simultaneous push/pop at count=1 → count stays 1; next mem_addr is the older entry.
- Misaligned, macro defined: SW addr 0x3001 → exc_ades single pulse, exc_addr=0x3001, no mem_req. Macro undefined: same stimulus → mem_req with mem_addr 0x3000, be 1111, exc_ades=0.
- Reset mid-drain: 2 entries queued, mem_ack=0, reset_n low asynchronously → mem_req drops immediately, empty=1, st_ready=1. After release, no stale request appears.
